serial_adder: RTL and testbench

Parametrised multi-cycle adder/subtractor that extends the half-adder truth table to WIDTH-bit operands with carry-in, subtract mode and signed-overflow detection. Operands are accepted over a valid/ready handshake and processed CHUNK bits per clock, LSB first, through a small FSM. The result is held on a valid/ready output port until consumed. The block sits in the arithmetic library as the area-economical alternative to a flat combinational adder.

---
 rtl/serial_adder.sv | 112 +++++++++++
 tb/tb_serial_adder.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Multi-cycle adder/subtractor that processes CHUNK bits per clock, LSB first.
// Operands arrive on a valid/ready handshake and the result is held until it is consumed.
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_c;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;
  logic             r_out_valid;

  logic             w_accept;
  logic             w_last;
  logic [CHUNK:0]   w_chunk_sum;
  logic             w_cmsb;
  logic [WIDTH-1:0] w_res_next;

  assign in_ready  = (r_state == IDLE) && !rst;
  assign w_accept  = in_valid && in_ready;
  assign w_last    = (r_cnt == CW'(N - 1));
  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;

  assign w_chunk_sum = {1'b0, r_a[CHUNK-1:0]} + {1'b0, r_b[CHUNK-1:0]} + {{CHUNK{1'b0}}, r_c};
  // Carry into the chunk's top bit recovered from its sum bit and operand bits.
  assign w_cmsb      = r_a[CHUNK-1] ^ r_b[CHUNK-1] ^ w_chunk_sum[CHUNK-1];
  assign w_res_next  = (r_res >> CHUNK) | (WIDTH'(w_chunk_sum[CHUNK-1:0]) << (WIDTH - CHUNK));

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_next = RUN;
      RUN:     if (w_last) w_state_next = DONE;
      DONE:    if (out_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_c         <= 1'b0;
      r_cnt       <= '0;
      r_res       <= '0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_a   <= a;
            r_b   <= sub ? ~b : b;
            r_c   <= sub | cin;
            r_cnt <= '0;
          end
        end
        RUN: begin
          r_a   <= r_a >> CHUNK;
          r_b   <= r_b >> CHUNK;
          r_c   <= w_chunk_sum[CHUNK];
          r_res <= w_res_next;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            r_sum       <= w_res_next;
            r_cout      <= w_chunk_sum[CHUNK];
            r_ovf       <= w_cmsb ^ w_chunk_sum[CHUNK];
            r_out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) r_out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: four WIDTH=8 instances (CHUNK 1/2/4/8) plus a WIDTH=1 half adder,
// random operands checked against an integer-arithmetic reference model.
module tb_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [3:0] iv;
  logic [3:0] ordy;
  wire  [3:0] irdy, ov, co, of;
  wire  [7:0] sm [4];
  logic [7:0] ta, tb_;
  logic       tcin, tsub;

  logic ha_iv, ha_a, ha_b;
  wire  ha_rdy, ha_ov, ha_s, ha_co, ha_of;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    serial_adder #(.WIDTH(8), .CHUNK(1 << g)) u_dut (
      .clk(clk), .rst(rst), .in_valid(iv[g]), .in_ready(irdy[g]),
      .a(ta), .b(tb_), .cin(tcin), .sub(tsub),
      .out_valid(ov[g]), .out_ready(ordy[g]),
      .sum(sm[g]), .cout(co[g]), .ovf(of[g]));
  end

  serial_adder #(.WIDTH(1), .CHUNK(1)) u_ha (
    .clk(clk), .rst(rst), .in_valid(ha_iv), .in_ready(ha_rdy),
    .a(ha_a), .b(ha_b), .cin(1'b0), .sub(1'b0),
    .out_valid(ha_ov), .out_ready(1'b1),
    .sum(ha_s), .cout(ha_co), .ovf(ha_of));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer arithmetic, unsigned for sum/cout and signed for overflow.
  task automatic model(input logic [7:0] a, input logic [7:0] b, input logic c, input logic s,
                       output logic [7:0] es, output logic ec, output logic eo);
    int ua, ub, sa, sb, ur, sr;
    ua = a; ub = b;
    sa = (a > 127) ? ua - 256 : ua;
    sb = (b > 127) ? ub - 256 : ub;
    ur = s ? (ua - ub) : (ua + ub + int'(c));
    es = 8'(ur & 255);
    ec = s ? (ua >= ub) : (ur > 255);
    sr = s ? (sa - sb) : (sa + sb + int'(c));
    eo = (sr > 127) || (sr < -128);
  endtask

  task automatic start_op(input int k, input logic [7:0] a, input logic [7:0] b,
                          input logic c, input logic s);
    int w;
    ta = a; tb_ = b; tcin = c; tsub = s;
    iv[k] = 1'b1;
    w = 0;
    while (!irdy[k] && w < 50) begin tick; w++; end
    chk("in_ready_wait", 32'(irdy[k]), 1);
    tick;
    iv[k] = 1'b0;
  endtask

  task automatic wait_ov(input int k, output int lat);
    lat = 0;
    while (!ov[k] && lat < 40) begin tick; lat++; end
  endtask

  task automatic run_op(input int k, input logic [7:0] a, input logic [7:0] b,
                        input logic c, input logic s,
                        output logic [7:0] gs, output logic gc, output logic go);
    int lat;
    logic [7:0] es;
    logic ec, eo;
    model(a, b, c, s, es, ec, eo);
    start_op(k, a, b, c, s);
    wait_ov(k, lat);
    chk("latency", lat, 8 >> k);
    gs = sm[k]; gc = co[k]; go = of[k];
    chk("sum", 32'(gs), 32'(es));
    chk("cout", 32'(gc), 32'(ec));
    chk("ovf", 32'(go), 32'(eo));
    tick;
    chk("out_valid_clear", 32'(ov[k]), 0);
    chk("in_ready_back", 32'(irdy[k]), 1);
  endtask

  initial begin
    logic [7:0] gs;
    logic gc, go;
    int lat, t1, t2, seen;

    rst = 1'b1; iv = '0; ordy = '1; ha_iv = 1'b0; ha_a = 1'b0; ha_b = 1'b0;
    ta = '0; tb_ = '0; tcin = 1'b0; tsub = 1'b0;
    tick; tick;
    chk("reset_out_valid", 32'(ov), 0);
    chk("reset_sum", 32'(sm[0]), 0);
    chk("reset_in_ready_low", 32'(irdy), 0);
    rst = 1'b0;
    #1;
    chk("in_ready_after_reset", 32'(irdy), 32'hF);

    // Half adder truth table
    for (int i = 0; i < 4; i++) begin
      ha_a = i[1]; ha_b = i[0]; ha_iv = 1'b1;
      lat = 0;
      while (!ha_rdy && lat < 20) begin tick; lat++; end
      tick;
      ha_iv = 1'b0;
      lat = 0;
      while (!ha_ov && lat < 20) begin tick; lat++; end
      chk("ha_latency", lat, 1);
      chk("ha_result", {30'd0, ha_co, ha_s}, 32'(int'(ha_a) + int'(ha_b)));
      tick;
    end

    // Directed add/sub cases
    run_op(0, 8'hFF, 8'h01, 1'b0, 1'b0, gs, gc, go);
    chk("ff+01", {23'd0, gc, go, gs}, {23'd0, 1'b1, 1'b0, 8'h00});
    run_op(0, 8'h7F, 8'h01, 1'b0, 1'b0, gs, gc, go);
    chk("7f+01", {23'd0, gc, go, gs}, {23'd0, 1'b0, 1'b1, 8'h80});
    run_op(0, 8'h10, 8'h20, 1'b1, 1'b0, gs, gc, go);
    chk("10+20+1", 32'(gs), 32'h31);
    run_op(0, 8'h05, 8'h07, 1'b0, 1'b1, gs, gc, go);
    chk("05-07", {23'd0, gc, go, gs}, {23'd0, 1'b0, 1'b0, 8'hFE});
    run_op(0, 8'h80, 8'h01, 1'b0, 1'b1, gs, gc, go);
    chk("80-01", {23'd0, gc, go, gs}, {23'd0, 1'b1, 1'b1, 8'h7F});
    run_op(0, 8'h80, 8'h01, 1'b1, 1'b1, gs, gc, go);
    chk("80-01_cin", {23'd0, gc, go, gs}, {23'd0, 1'b1, 1'b1, 8'h7F});

    // Random vectors across all chunk widths
    for (int k = 0; k < 4; k++)
      for (int i = 0; i < 1000; i++)
        run_op(k, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), gs, gc, go);

    // Backpressure with in_valid held during RUN/DONE
    ordy[0] = 1'b0;
    start_op(0, 8'h12, 8'h34, 1'b0, 1'b0);
    ta = 8'hFF; tb_ = 8'hFF; iv[0] = 1'b1;
    wait_ov(0, lat);
    chk("bp_latency", lat, 8);
    chk("bp_sum", 32'(sm[0]), 32'h46);
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("bp_hold_valid", 32'(ov[0]), 1);
      chk("bp_hold_sum", 32'(sm[0]), 32'h46);
      chk("bp_hold_flags", {30'd0, co[0], of[0]}, 0);
      chk("bp_in_ready_low", 32'(irdy[0]), 0);
    end
    iv[0] = 1'b0; ordy[0] = 1'b1;
    tick;
    chk("bp_release_valid", 32'(ov[0]), 0);
    chk("bp_release_ready", 32'(irdy[0]), 1);
    seen = 0;
    for (int i = 0; i < 10; i++) begin tick; if (ov[0]) seen = 1; end
    chk("bp_no_ghost_op", seen, 0);

    // Back-to-back spacing with in_valid and out_ready held high
    ta = 8'h21; tb_ = 8'h10; tcin = 1'b0; tsub = 1'b0; iv[0] = 1'b1;
    wait_ov(0, lat);
    tick;
    chk("b2b_consumed", 32'(ov[0]), 0);
    t1 = cyc;
    wait_ov(0, lat);
    t2 = cyc;
    iv[0] = 1'b0;
    chk("b2b_gap", t2 - t1, 9);
    chk("b2b_sum", 32'(sm[0]), 32'h31);
    tick;

    // Reset at the third RUN cycle
    start_op(0, 8'hAA, 8'h55, 1'b0, 1'b0);
    tick; tick;
    rst = 1'b1;
    #1;
    chk("rst_in_ready_low", 32'(irdy[0]), 0);
    tick;
    rst = 1'b0;
    #1;
    chk("rst_run_in_ready", 32'(irdy[0]), 1);
    chk("rst_run_outputs", {21'd0, ov[0], co[0], of[0], sm[0]}, 0);
    seen = 0;
    for (int i = 0; i < 12; i++) begin tick; if (ov[0]) seen = 1; end
    chk("rst_run_no_output", seen, 0);
    run_op(0, 8'h01, 8'h01, 1'b0, 1'b0, gs, gc, go);
    chk("after_rst_01+01", 32'(gs), 32'h02);

    // Reset while a result is held
    ordy[0] = 1'b0;
    start_op(0, 8'h33, 8'h44, 1'b0, 1'b0);
    wait_ov(0, lat);
    chk("done_sum", 32'(sm[0]), 32'h77);
    tick;
    chk("done_held", 32'(ov[0]), 1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    #1;
    chk("rst_done_outputs", {21'd0, ov[0], co[0], of[0], sm[0]}, 0);
    chk("rst_done_in_ready", 32'(irdy[0]), 1);
    ordy[0] = 1'b1;
    seen = 0;
    for (int i = 0; i < 5; i++) begin tick; if (ov[0]) seen = 1; end
    chk("rst_done_dropped", seen, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
